// File: rtl/alu_pkg.sv
// Shared widths, limits and the result entry record
// for the multiplier result stage.
package alu_pkg;

    localparam int PW   = 16;
    localparam int ACCW = 24;
    localparam int RW   = 8;

    localparam logic signed [ACCW-1:0] SAT_MAX = 24'sd127;
    localparam logic signed [ACCW-1:0] SAT_MIN = -24'sd128;
    localparam logic signed [ACCW-1:0] ACC_MAX =
        {1'b0, {(ACCW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] ACC_MIN =
        {1'b1, {(ACCW-1){1'b0}}};

    typedef struct packed {
        logic signed [ACCW-1:0] value;
        logic [RW-1:0]          sat;
        logic                   zero;
        logic                   neg;
        logic                   ovf;
    } entry_t;

    function automatic entry_t make_entry(
        input logic signed [ACCW-1:0] v
    );
        entry_t e;
        e.value = v;
        e.zero  = (v == '0);
        e.neg   = v[ACCW-1];
        e.ovf   = 1'b0;
        e.sat   = v[RW-1:0];
        if (v > SAT_MAX) begin
            e.sat = {1'b0, {(RW-1){1'b1}}};
            e.ovf = 1'b1;
        end else if (v < SAT_MIN) begin
            e.sat = {1'b1, {(RW-1){1'b0}}};
            e.ovf = 1'b1;
        end
        return e;
    endfunction

endpackage

// File: rtl/mult_result_stage_if.sv
// Product-in / result-out handshake bundle of the
// multiplier result stage.
interface mult_result_stage_if;
    import alu_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic signed [PW-1:0]   in_prod;
    logic                   in_acc;
    logic                   acc_clr;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [ACCW-1:0] out_value;
    logic [RW-1:0]          out_sat;
    logic                   out_zero;
    logic                   out_neg;
    logic                   out_ovf;
    logic                   acc_sat;

    modport master (
        output in_valid, in_prod, in_acc,
        output acc_clr, out_ready,
        input  in_ready, out_valid, out_value,
        input  out_sat, out_zero, out_neg,
        input  out_ovf, acc_sat
    );

    modport slave (
        input  in_valid, in_prod, in_acc,
        input  acc_clr, out_ready,
        output in_ready, out_valid, out_value,
        output out_sat, out_zero, out_neg,
        output out_ovf, acc_sat
    );

endinterface

// File: rtl/result_fifo.sv
// Generic DEPTH-entry valid/ready FIFO of result
// entries; outputs read zero while empty.
module result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push_valid_i,
    output logic   push_ready_o,
    input  entry_t push_data_i,
    output logic   pop_valid_o,
    input  logic   pop_ready_i,
    output entry_t pop_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t         mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           push, pop;

    assign push_ready_o = (cnt_q != CW'(DEPTH));
    assign pop_valid_o  = (cnt_q != '0);
    assign push = push_valid_i & push_ready_o;
    assign pop  = pop_valid_o & pop_ready_i;

    // DEPTH is a power of two, so pointers wrap freely
    always_comb begin
        wptr_d = wptr_q + AW'(push);
        rptr_d = rptr_q + AW'(pop);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_data_i;
    end

    assign pop_data_o = pop_valid_o ? mem_q[rptr_q] : '0;

endmodule

// File: rtl/mult_result_stage.sv
// Multiplier result stage: optional saturating
// accumulate, 8-bit clamp and flags, FIFO output.
module mult_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic clk,
    input logic rst,
    mult_result_stage_if.slave bus
);

    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   sat_q, sat_d;
    logic signed [ACCW-1:0] base, sext;
    logic signed [ACCW-1:0] clamp, value;
    logic signed [ACCW:0]   sum;
    logic                   clip, push_ready, push;
    entry_t                 head;

    // A clear at the same edge wins over the old total
    assign base = bus.acc_clr ? '0 : acc_q;
    assign sext = {{(ACCW-PW){bus.in_prod[PW-1]}},
                   bus.in_prod};
    assign sum  = {base[ACCW-1], base}
                + {sext[ACCW-1], sext};
    assign clip = sum[ACCW] ^ sum[ACCW-1];

    always_comb begin
        clamp = sum[ACCW-1:0];
        if (clip) clamp = sum[ACCW] ? ACC_MIN : ACC_MAX;
    end

    assign value = bus.in_acc ? clamp : sext;
    assign push  = bus.in_valid & push_ready;

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (bus.acc_clr) begin
            acc_d = '0;
            sat_d = 1'b0;
        end
        if (push && bus.in_acc) begin
            acc_d = clamp;
            sat_d = sat_d | clip;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (bus.in_valid),
        .push_ready_o (push_ready),
        .push_data_i  (make_entry(value)),
        .pop_valid_o  (bus.out_valid),
        .pop_ready_i  (bus.out_ready),
        .pop_data_o   (head)
    );

    assign bus.in_ready  = push_ready;
    assign bus.out_value = head.value;
    assign bus.out_sat   = head.sat;
    assign bus.out_zero  = head.zero;
    assign bus.out_neg   = head.neg;
    assign bus.out_ovf   = head.ovf;
    assign bus.acc_sat   = sat_q;

endmodule

// File: tb/tb_mult_result_stage.sv
// Scoreboard bench for the multiplier result stage.
module tb_mult_result_stage;

    typedef struct packed {
        logic [23:0] value;
        logic [7:0]  sat;
        logic        zero;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    exp_t    q[$];
    longint  m_acc;
    bit      m_sat;

    mult_result_stage_if bus();

    mult_result_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input longint v);
        exp_t e;
        e.value = v[23:0];
        e.zero  = (v == 0);
        e.neg   = (v < 0);
        e.ovf   = (v > 127) || (v < -128);
        if (v > 127)       e.sat = 8'h7F;
        else if (v < -128) e.sat = 8'h80;
        else               e.sat = v[7:0];
        return e;
    endfunction

    task automatic tick(input bit v,
                        input logic [15:0] p,
                        input bit a, input bit c,
                        input bit r);
        bit      f_in, f_out;
        exp_t    e, h;
        shortint sp;
        longint  s;
        bus.in_valid  = v;
        bus.in_prod   = p;
        bus.in_acc    = a;
        bus.acc_clr   = c;
        bus.out_ready = r;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== (q.size() != 0)) begin
            n_bad++;
            $display("FAIL out_valid got %b want %b",
                     bus.out_valid, q.size() != 0);
        end
        n_cmp++;
        if (bus.in_ready !== (q.size() < 2)) begin
            n_bad++;
            $display("FAIL in_ready got %b want %b",
                     bus.in_ready, q.size() < 2);
        end
        n_cmp++;
        if (bus.acc_sat !== m_sat) begin
            n_bad++;
            $display("FAIL acc_sat got %b want %b",
                     bus.acc_sat, m_sat);
        end
        h = {bus.out_value, bus.out_sat,
             bus.out_zero, bus.out_neg, bus.out_ovf};
        e = (q.size() != 0) ? q[0] : '0;
        n_cmp++;
        if (h !== e) begin
            n_bad++;
            $display("FAIL head got %h/%h/%b%b%b want %h/%h/%b%b%b",
                     h.value, h.sat, h.zero, h.neg, h.ovf,
                     e.value, e.sat, e.zero, e.neg, e.ovf);
        end
        f_out = r && (q.size() != 0);
        f_in  = v && (q.size() < 2);
        @(posedge clk);
        if (f_out) h = q.pop_front();
        if (c) begin
            m_acc = 0;
            m_sat = 0;
        end
        if (f_in) begin
            sp = p;
            if (a) begin
                s = m_acc + longint'(sp);
                if (s > 8388607) begin
                    s = 8388607;
                    m_sat = 1;
                end else if (s < -8388608) begin
                    s = -8388608;
                    m_sat = 1;
                end
                m_acc = s;
                q.push_back(model(s));
            end else begin
                q.push_back(model(longint'(sp)));
            end
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && q.size() != 0; i++)
            tick(0, 16'h0, 0, 0, 1);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain left %0d want 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid  = 0;
        bus.in_prod   = '0;
        bus.in_acc    = 0;
        bus.acc_clr   = 0;
        bus.out_ready = 0;
        m_acc = 0;
        m_sat = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.out_value !== 24'h0 || bus.out_sat !== 8'h0 ||
            bus.acc_sat !== 1'b0 ||
            {bus.out_zero, bus.out_neg, bus.out_ovf} !== 3'b0) begin
            n_bad++;
            $display("FAIL reset got v=%b r=%b val=%h sat=%h as=%b want 0 1 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out_value,
                     bus.out_sat, bus.acc_sat);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pass();
        tick(1, 16'h0014, 0, 0, 1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 ||
            bus.out_value !== 24'h000014 ||
            bus.out_sat !== 8'h14 ||
            {bus.out_zero, bus.out_neg, bus.out_ovf} !== 3'b000) begin
            n_bad++;
            $display("FAIL pass got v=%b val=%h sat=%h want 1 000014 14",
                     bus.out_valid, bus.out_value, bus.out_sat);
        end
        drain();
    endtask

    task automatic test_neg_clamp();
        tick(1, 16'hFF88, 0, 0, 1);
        n_cmp++;
        if (bus.out_value !== 24'hFFFF88 || bus.out_sat !== 8'h88 ||
            bus.out_neg !== 1'b1 || bus.out_ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL neg got %h/%h n=%b o=%b want FFFF88/88 1 0",
                     bus.out_value, bus.out_sat,
                     bus.out_neg, bus.out_ovf);
        end
        tick(1, 16'h1000, 0, 0, 1);
        n_cmp++;
        if (bus.out_sat !== 8'h7F || bus.out_ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_hi got %h o=%b want 7F 1",
                     bus.out_sat, bus.out_ovf);
        end
        tick(1, 16'hF000, 0, 0, 1);
        n_cmp++;
        if (bus.out_sat !== 8'h80 || bus.out_ovf !== 1'b1 ||
            bus.out_neg !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_lo got %h o=%b n=%b want 80 1 1",
                     bus.out_sat, bus.out_ovf, bus.out_neg);
        end
        drain();
    endtask

    task automatic test_accumulate();
        logic [23:0] wv [3];
        wv[0] = 24'd100;
        wv[1] = 24'd200;
        wv[2] = 24'd300;
        tick(0, 16'h0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1, 16'd100, 1, 0, 1);
            n_cmp++;
            if (bus.out_value !== wv[i]) begin
                n_bad++;
                $display("FAIL acc%0d got %0d want %0d",
                         i, bus.out_value, wv[i]);
            end
        end
        tick(1, 16'd5, 1, 1, 1);
        n_cmp++;
        if (bus.out_value !== 24'd5) begin
            n_bad++;
            $display("FAIL acc_clr_same got %0d want 5",
                     bus.out_value);
        end
        drain();
    endtask

    task automatic test_backpressure();
        tick(1, 16'd1, 0, 0, 0);
        tick(1, 16'd2, 0, 0, 0);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full in_ready got %b want 0",
                     bus.in_ready);
        end
        tick(1, 16'd3, 0, 0, 0);
        tick(1, 16'd3, 0, 0, 1);
        tick(1, 16'd3, 0, 0, 1);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 ||
            bus.out_value !== 24'd3) begin
            n_bad++;
            $display("FAIL pushpop got v=%b r=%b val=%0d want 1 1 3",
                     bus.out_valid, bus.in_ready, bus.out_value);
        end
        drain();
    endtask

    task automatic test_acc_sat();
        tick(0, 16'h0, 0, 1, 1);
        for (int i = 0; i < 257; i++)
            tick(1, 16'h7FFF, 1, 0, 1);
        n_cmp++;
        if (bus.out_value !== 24'h7FFFFF ||
            bus.acc_sat !== 1'b1) begin
            n_bad++;
            $display("FAIL acc_sat_hi got %h as=%b want 7FFFFF 1",
                     bus.out_value, bus.acc_sat);
        end
        drain();
        tick(0, 16'h0, 0, 1, 1);
        n_cmp++;
        if (bus.acc_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL acc_sat_clr got %b want 0",
                     bus.acc_sat);
        end
    endtask

    task automatic test_async_reset();
        tick(0, 16'h0, 0, 1, 1);
        tick(1, 16'd100, 1, 0, 0);
        tick(1, 16'd100, 1, 0, 1);
        tick(1, 16'd100, 1, 0, 0);
        bus.in_valid  = 0;
        bus.acc_clr   = 0;
        bus.out_ready = 0;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.acc_sat !== 1'b0 || bus.out_value !== 24'h0) begin
            n_bad++;
            $display("FAIL async_rst got v=%b r=%b as=%b val=%h want 0 1 0 0",
                     bus.out_valid, bus.in_ready,
                     bus.acc_sat, bus.out_value);
        end
        q.delete();
        m_acc = 0;
        m_sat = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tick(1, 16'd7, 1, 0, 1);
        n_cmp++;
        if (bus.out_value !== 24'd7) begin
            n_bad++;
            $display("FAIL post_rst got %0d want 7",
                     bus.out_value);
        end
        drain();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_pass();
        test_neg_clamp();
        test_accumulate();
        test_backpressure();
        test_acc_sat();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_result_stage.md
Name: mult_result_stage

Overview:
- Downstream stage of the 8-bit sequential shift-add multiplier.
- Accepts each finished signed 16-bit product and optionally accumulates it into a signed 24-bit running total (MAC-style).
- Derives an 8-bit saturated ALU result plus status flags.
- Buffers results in a 2-entry FIFO behind a valid/ready handshake toward the ALU writeback/output logic.

Parameters:
- PW, 16, product width (signed, two's complement).
- ACCW, 24, accumulator and entry value width (signed).
- RW, 8, saturated result width (signed).
- DEPTH, 2, FIFO entries (power of two, >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  product available from the multiplier.
- in_ready  output  1  stage can accept a product; equals !full, independent of out_ready.
- in_prod  input  PW  signed product.
- in_acc  input  1  with the transfer: add in_prod to the accumulator instead of passing it through.
- acc_clr  input  1  clear the accumulator and its sticky flag.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer takes the head.
- out_value  output  ACCW  head full-precision signed value.
- out_sat  output  RW  head value saturated to [-128, 127].
- out_zero  output  1  head value == 0.
- out_neg  output  1  head value < 0.
- out_ovf  output  1  head value outside the RW range (out_sat clamped).
- acc_sat  output  1  sticky: accumulator has clamped since the last clear or reset.

Behaviour:
- Reset (rst low, asynchronous, immediate):
  - FIFO empty; out_valid=0; in_ready=1.
  - Accumulator=0; acc_sat=0.
  - out_value, out_sat and all flags 0.
- Reset mid-operation discards all buffered entries. The first edge after rst rises behaves as after power-up.
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- Entry value on an input transfer:
  - in_acc=0: sign-extend in_prod to ACCW. Accumulator unchanged.
  - in_acc=1: sum = acc + sext(in_prod), computed at ACCW+1 bits and clamped to [-2^23, 2^23-1]. Accumulator and entry both take the clamped sum. If clamping occurred, acc_sat is set.
- acc_clr:
  - Without a transfer: accumulator=0 and acc_sat=0 at that edge.
  - With an accumulating transfer at the same edge: the clear applies first, so acc = sext(in_prod), entry = sext(in_prod), and acc_sat=0.
- Flags and saturation are computed at write time and stored per entry:
  - out_sat = 0x7F if value > 127; 0x80 if value < -128; else value[7:0].
  - out_ovf = 1 whenever out_sat is clamped.
- Latency: a product accepted at edge k appears at the head with out_valid=1 after edge k, when the FIFO was empty.
- FIFO:
  - Read/write pointers wrap modulo DEPTH, with a count register.
  - Full: count==DEPTH, in_ready=0, and in_valid is ignored.
  - Empty: out_valid=0, out_value/out_sat/flags driven 0, and out_ready is ignored.
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged and order preserved.
  - Push while empty with out_ready=1: no bypass; the entry is visible the next cycle.
- Head data is held stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready to in_ready.

Decomposition:
- Shared package (alu_pkg):
  - Width constants PW, ACCW, RW.
  - RW limits SAT_MAX=127 and SAT_MIN=-128.
  - ACCW limits.
  - Entry record typedef: value, sat, zero, neg, ovf.
- One sub-module: result_fifo, a generic DEPTH-entry valid/ready FIFO of entry records. Saturation and accumulate logic stay in mult_result_stage.

Test Plan:
- Pass-through: in_prod=0x0014, in_acc=0, out_ready=1 -> next cycle out_valid=1, out_value=0x000014, out_sat=0x14, zero/neg/ovf=0/0/0.
- Negative and clamp:
  - in_prod=0xFF88 (-120) -> out_value=0xFFFF88, out_sat=0x88, neg=1, ovf=0.
  - Then in_prod=0x1000 (4096) -> out_sat=0x7F, ovf=1.
  - Then in_prod=0xF000 -> out_sat=0x80, ovf=1, neg=1.
- Accumulate: acc_clr pulse, then 100,100,100 with in_acc=1 -> out_value 100, 200, 300; out_sat 0x64, 0x7F, 0x7F; ovf 0, 1, 1. Then acc_clr together with in_prod=5, in_acc=1 -> out_value=5.
- Backpressure:
  - out_ready=0, offer products 1, 2, 3 on consecutive cycles -> in_ready falls after 2 accepted; 3 is held.
  - Raise out_ready -> outputs 1, 2, 3 in order.
  - Push and pop in the same cycle at count=1 -> count stays 1.
- Accumulator saturation: acc_clr, then 257 transfers of 0x7FFF with in_acc=1 -> final out_value=0x7FFFFF, acc_sat=1. acc_clr -> acc_sat=0.
- Async reset: with 2 entries queued and acc=300, pull rst low between edges -> out_valid=0, in_ready=1, acc_sat=0 immediately. After release, in_prod=7 with in_acc=1 -> out_value=7.
